float_conv_arbiter: RTL and testbench

FLOAT_CONV_ARBITER -- requirements
Module: float_conv_arbiter

---
 rtl/float_conv_pkg.sv | 9 +
 rtl/float_conv_tag_fifo.sv | 41 ++++
 rtl/float_conv_arbiter.sv | 90 +++++++++
 tb/tb_float_conv_arbiter.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/float_conv_pkg.sv
// float_conv_pkg: shared sizing for the float converter arbiter and its tag FIFO.
package float_conv_pkg;
  localparam int N_REQ = 4;
  localparam int TAG_DEPTH = 8;
  localparam int OPW = 8;
  localparam int RESW = 16;
  localparam int IDW = $clog2(N_REQ);
  localparam int CNTW = $clog2(TAG_DEPTH) + 1;
endpackage

// File: rtl/float_conv_tag_fifo.sv
// float_conv_tag_fifo: synchronous FIFO of requester ids in converter issue order.
module float_conv_tag_fifo
  import float_conv_pkg::*;
(
  input  logic            aclk,
  input  logic            aresetn,
  input  logic            push,
  input  logic [IDW-1:0]  din,
  input  logic            pop,
  output logic [IDW-1:0]  dout,
  output logic [CNTW-1:0] count,
  output logic            empty
);
  localparam int AW = CNTW - 1;
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic [IDW-1:0] mem_q [TAG_DEPTH];
  // Pointers wrap naturally because the depth is a power of two.
  always_comb begin
    wr_d = wr_q + AW'(push);
    rd_d = rd_q + AW'(pop);
    cnt_d = cnt_q + CNTW'(push) - CNTW'(pop);
  end
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
      cnt_q <= cnt_d;
    end
  end
  always_ff @(posedge aclk) begin
    if (push) mem_q[wr_q] <= din;
  end
  assign dout = mem_q[rd_q];
  assign count = cnt_q;
  assign empty = cnt_q == '0;
endmodule

// File: rtl/float_conv_arbiter.sv
// float_conv_arbiter: round-robin arbiter feeding one in-order float converter,
// tagging each operand with its requester id and routing results back.
module float_conv_arbiter
  import float_conv_pkg::*;
(
  input  logic                 aclk,
  input  logic                 aresetn,
  input  logic [N_REQ-1:0]     s_req_tvalid,
  input  logic [OPW*N_REQ-1:0] s_req_tdata,
  output logic [N_REQ-1:0]     s_req_tready,
  output logic                 m_conv_a_tvalid,
  output logic [OPW-1:0]       m_conv_a_tdata,
  input  logic                 m_conv_a_tready,
  input  logic                 s_conv_result_tvalid,
  input  logic [RESW-1:0]      s_conv_result_tdata,
  output logic                 s_conv_result_tready,
  output logic                 m_res_tvalid,
  output logic [RESW-1:0]      m_res_tdata,
  output logic [IDW-1:0]       m_res_tid,
  input  logic                 m_res_tready,
  output logic                 err_orphan
);
  logic iss_valid_q, iss_valid_d, err_orphan_q, err_orphan_d;
  logic [OPW-1:0] iss_data_q, iss_data_d;
  logic [IDW-1:0] iss_id_q, iss_id_d, rr_ptr_q, rr_ptr_d, gnt_idx, fifo_head;
  logic [CNTW-1:0] fifo_cnt;
  logic fifo_empty, gnt_found, can_acc, req_hs, conv_hs, res_hs;
  always_comb begin
    logic [IDW-1:0] idx;
    idx = '0;
    gnt_found = 1'b0;
    gnt_idx = '0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = IDW'((int'(rr_ptr_q) + k) % N_REQ);
      if (!gnt_found && s_req_tvalid[idx]) begin
        gnt_found = 1'b1;
        gnt_idx = idx;
      end
    end
  end
  // The issue slot counts as outstanding so the FIFO can never be pushed when full.
  always_comb begin
    can_acc = (!iss_valid_q || m_conv_a_tready) &&
              (({1'b0, fifo_cnt} + (CNTW+1)'(iss_valid_q)) < (CNTW+1)'(TAG_DEPTH));
    req_hs = aresetn && gnt_found && can_acc;
    conv_hs = iss_valid_q && m_conv_a_tready;
    res_hs = m_res_tvalid && m_res_tready;
    iss_valid_d = req_hs || (iss_valid_q && !m_conv_a_tready);
    iss_data_d = req_hs ? s_req_tdata[gnt_idx*OPW +: OPW] : iss_data_q;
    iss_id_d = req_hs ? gnt_idx : iss_id_q;
    rr_ptr_d = !req_hs ? rr_ptr_q : (int'(gnt_idx) == N_REQ - 1) ? '0 : gnt_idx + 1'b1;
    err_orphan_d = err_orphan_q || (fifo_empty && s_conv_result_tvalid);
  end
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      iss_valid_q <= 1'b0;
      iss_data_q <= '0;
      iss_id_q <= '0;
      rr_ptr_q <= '0;
      err_orphan_q <= 1'b0;
    end else begin
      iss_valid_q <= iss_valid_d;
      iss_data_q <= iss_data_d;
      iss_id_q <= iss_id_d;
      rr_ptr_q <= rr_ptr_d;
      err_orphan_q <= err_orphan_d;
    end
  end
  // With no tag outstanding, result beats are swallowed and flagged as orphans.
  always_comb begin
    s_req_tready = req_hs ? N_REQ'(1) << gnt_idx : '0;
    m_conv_a_tvalid = iss_valid_q;
    m_conv_a_tdata = iss_data_q;
    m_res_tvalid = !fifo_empty && s_conv_result_tvalid;
    m_res_tdata = fifo_empty ? '0 : s_conv_result_tdata;
    m_res_tid = fifo_empty ? '0 : fifo_head;
    s_conv_result_tready = fifo_empty || m_res_tready;
    err_orphan = err_orphan_q;
  end
  float_conv_tag_fifo u_tag_fifo (
    .aclk    (aclk),
    .aresetn (aresetn),
    .push    (conv_hs),
    .din     (iss_id_q),
    .pop     (res_hs),
    .dout    (fifo_head),
    .count   (fifo_cnt),
    .empty   (fifo_empty)
  );
endmodule

// File: tb/tb_float_conv_arbiter.sv
// tb_float_conv_arbiter: table-driven grant checks plus a scoreboard that follows
// every accepted operand through an in-order converter model to the routed result.
module tb_float_conv_arbiter;
  import float_conv_pkg::*;
  logic aclk = 1'b0, aresetn = 1'b0;
  logic [N_REQ-1:0] s_req_tvalid = '0, s_req_tready;
  logic [OPW*N_REQ-1:0] s_req_tdata = '0;
  logic m_conv_a_tvalid, m_conv_a_tready = 1'b1;
  logic [OPW-1:0] m_conv_a_tdata;
  logic s_conv_result_tvalid = 1'b0, s_conv_result_tready;
  logic [RESW-1:0] s_conv_result_tdata = '0, m_res_tdata;
  logic m_res_tvalid, m_res_tready = 1'b1, err_orphan;
  logic [IDW-1:0] m_res_tid;
  typedef struct {
    logic [3:0] vld;
    logic [7:0] d;
    logic [3:0] rdy;
  } vec_t;
  vec_t tbl[13];
  logic [17:0] sb_q[$];
  logic [7:0] conv_q[$];
  logic [17:0] e;
  logic [7:0] lat_data;
  logic lat_pend = 1'b0, orphan_drv = 1'b0;
  int vectors = 0, miscompares = 0, hs_cnt = 0, h0;

  float_conv_arbiter dut (
    .aclk (aclk), .aresetn (aresetn),
    .s_req_tvalid (s_req_tvalid), .s_req_tdata (s_req_tdata), .s_req_tready (s_req_tready),
    .m_conv_a_tvalid (m_conv_a_tvalid), .m_conv_a_tdata (m_conv_a_tdata), .m_conv_a_tready (m_conv_a_tready),
    .s_conv_result_tvalid (s_conv_result_tvalid), .s_conv_result_tdata (s_conv_result_tdata),
    .s_conv_result_tready (s_conv_result_tready),
    .m_res_tvalid (m_res_tvalid), .m_res_tdata (m_res_tdata), .m_res_tid (m_res_tid),
    .m_res_tready (m_res_tready), .err_orphan (err_orphan)
  );

  always #5 aclk = ~aclk;

  function automatic logic [15:0] cvt(input logic [7:0] x);
    return {x ^ 8'h5A, ~x};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step;
    @(posedge aclk);
    #1;
  endtask

  task automatic set_req(input logic [3:0] v, input logic [7:0] d);
    s_req_tvalid = v;
    for (int i = 0; i < N_REQ; i++) s_req_tdata[8*i +: 8] = d + 8'(i);
  endtask

  task automatic drain;
    s_req_tvalid = '0;
    m_res_tready = 1'b1;
    m_conv_a_tready = 1'b1;
    for (int c = 0; c < 100 && (sb_q.size() != 0 || m_conv_a_tvalid); c++) step;
    chk("drain_left", 32'(sb_q.size()), 0);
  endtask

  // In-order converter model: one result per accepted operand, presented next cycle.
  always begin
    @(posedge aclk);
    #1;
    s_conv_result_tvalid = orphan_drv || conv_q.size() != 0;
    s_conv_result_tdata = orphan_drv ? 16'h1234 : conv_q.size() != 0 ? cvt(conv_q[0]) : 16'h0;
  end

  always @(negedge aclk) begin
    if (!aresetn) begin
      sb_q.delete();
      conv_q.delete();
      lat_pend = 1'b0;
    end else begin
      if (lat_pend) begin
        chk("issue_valid", 32'(m_conv_a_tvalid), 1);
        chk("issue_data", 32'(m_conv_a_tdata), 32'(lat_data));
      end
      lat_pend = 1'b0;
      chk("ready_onehot", 32'($onehot0(s_req_tready)), 1);
      for (int i = 0; i < N_REQ; i++)
        if (s_req_tvalid[i] && s_req_tready[i]) begin
          sb_q.push_back({IDW'(i), cvt(s_req_tdata[8*i +: 8])});
          lat_pend = 1'b1;
          lat_data = s_req_tdata[8*i +: 8];
          hs_cnt++;
        end
      if (m_conv_a_tvalid && m_conv_a_tready) conv_q.push_back(m_conv_a_tdata);
      if (s_conv_result_tvalid && s_conv_result_tready && conv_q.size() != 0) void'(conv_q.pop_front());
      if (m_res_tvalid && m_res_tready) begin
        if (sb_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL res_unexpected: got tid %0h data %0h, want no result", m_res_tid, m_res_tdata);
        end else begin
          e = sb_q.pop_front();
          chk("res_tid", 32'(m_res_tid), 32'(e[17:16]));
          chk("res_data", 32'(m_res_tdata), 32'(e[15:0]));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    tbl[0]  = '{4'b1111, 8'h20, 4'b0001};
    tbl[1]  = '{4'b1111, 8'h30, 4'b0010};
    tbl[2]  = '{4'b1111, 8'h40, 4'b0100};
    tbl[3]  = '{4'b1111, 8'h50, 4'b1000};
    tbl[4]  = '{4'b1111, 8'h60, 4'b0001};
    tbl[5]  = '{4'b0000, 8'h70, 4'b0000};
    tbl[6]  = '{4'b0001, 8'h80, 4'b0001};
    tbl[7]  = '{4'b1001, 8'h90, 4'b1000};
    tbl[8]  = '{4'b0110, 8'hA0, 4'b0010};
    tbl[9]  = '{4'b0110, 8'hB0, 4'b0100};
    tbl[10] = '{4'b0011, 8'hC0, 4'b0001};
    tbl[11] = '{4'b1100, 8'hD0, 4'b0100};
    tbl[12] = '{4'b0001, 8'h3F, 4'b0001};
    set_req(4'b1111, 8'h00);
    @(negedge aclk);
    chk("rst_req_tready", 32'(s_req_tready), 0);
    chk("rst_conv_tvalid", 32'(m_conv_a_tvalid), 0);
    chk("rst_res_tvalid", 32'(m_res_tvalid), 0);
    chk("rst_res_tready", 32'(s_conv_result_tready), 1);
    chk("rst_err", 32'(err_orphan), 0);
    step;
    aresetn = 1'b1;
    set_req(4'b0000, 8'h00);
    foreach (tbl[r]) begin
      step;
      set_req(tbl[r].vld, tbl[r].d);
      @(negedge aclk);
      chk($sformatf("grant_%0d", r), 32'(s_req_tready), 32'(tbl[r].rdy));
    end
    drain;
    // Result backpressure: tag capacity caps acceptance at TAG_DEPTH.
    m_res_tready = 1'b0;
    h0 = hs_cnt;
    step;
    set_req(4'b0010, 8'h11);
    repeat (20) step;
    @(negedge aclk);
    chk("full_accepts", 32'(hs_cnt - h0), 8);
    chk("full_ready", 32'(s_req_tready), 0);
    step;
    m_res_tready = 1'b1;
    for (int c = 0; c < 10 && hs_cnt == h0 + 8; c++) @(negedge aclk);
    chk("resume_accepts", 32'(hs_cnt - h0), 9);
    drain;
    // Converter stall holds the issue register.
    step;
    m_conv_a_tready = 1'b0;
    set_req(4'b0100, 8'h75);
    @(negedge aclk);
    chk("stall_first_grant", 32'(s_req_tready), 32'(4'b0100));
    step;
    s_req_tdata[23:16] = 8'h88;
    repeat (5) begin
      @(negedge aclk);
      chk("stall_valid", 32'(m_conv_a_tvalid), 1);
      chk("stall_data", 32'(m_conv_a_tdata), 32'h77);
      chk("stall_no_grant", 32'(s_req_tready), 0);
      step;
    end
    m_conv_a_tready = 1'b1;
    @(negedge aclk);
    chk("stall_release_grant", 32'(s_req_tready), 32'(4'b0100));
    drain;
    // Orphan result with no tag outstanding.
    @(negedge aclk);
    orphan_drv = 1'b1;
    @(negedge aclk);
    chk("orphan_res_tvalid", 32'(m_res_tvalid), 0);
    chk("orphan_tready", 32'(s_conv_result_tready), 1);
    chk("orphan_err_pre", 32'(err_orphan), 0);
    orphan_drv = 1'b0;
    @(negedge aclk);
    chk("orphan_err_set", 32'(err_orphan), 1);
    repeat (5) @(negedge aclk);
    chk("orphan_err_sticky", 32'(err_orphan), 1);
    // Asynchronous reset with operations in flight.
    step;
    m_res_tready = 1'b0;
    set_req(4'b1111, 8'h50);
    repeat (3) step;
    set_req(4'b0000, 8'h00);
    repeat (2) step;
    set_req(4'b1111, 8'h60);
    aresetn = 1'b0;
    #1;
    chk("arst_req_tready", 32'(s_req_tready), 0);
    chk("arst_conv_tvalid", 32'(m_conv_a_tvalid), 0);
    chk("arst_conv_tdata", 32'(m_conv_a_tdata), 0);
    chk("arst_res_tvalid", 32'(m_res_tvalid), 0);
    chk("arst_res_tdata", 32'(m_res_tdata), 0);
    chk("arst_res_tid", 32'(m_res_tid), 0);
    chk("arst_res_tready", 32'(s_conv_result_tready), 1);
    chk("arst_err", 32'(err_orphan), 0);
    repeat (2) step;
    aresetn = 1'b1;
    @(negedge aclk);
    chk("post_rst_grant", 32'(s_req_tready), 32'(4'b0001));
    chk("post_rst_res_tvalid", 32'(m_res_tvalid), 0);
    chk("post_rst_err", 32'(err_orphan), 0);
    step;
    drain;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
